// File: rtl/rgmii_inband_status.sv
// RGMII in-band status filter: debounces the idle-time RXD nibble into committed link/speed/duplex.
// Latency: commit lands 2 clocks after the final matching sample reaches stage 1; no backpressure (free-running).
module rgmii_inband_status #(
    parameter int MATCH_COUNT    = 8,
    parameter int STALE_TIMEOUT  = 1024,
    parameter int BAD_COUNT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_ctl_rise,
    input  logic                      rx_ctl_fall,
    input  logic [3:0]                rxd_rise,
    output logic                      rx_link_up,
    output logic                      rx_speed_10,
    output logic                      rx_speed_100,
    output logic                      rx_speed_1000,
    output logic                      rx_full_duplex,
    output logic                      status_valid,
    output logic                      status_changed,
    output logic                      status_stale,
    output logic [BAD_COUNT_BITS-1:0] bad_code_count
);

    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(STALE_TIMEOUT + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(MATCH_COUNT);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_TIMEOUT);

    logic          s1_ctl_rise;
    logic          s1_ctl_fall;
    logic [3:0]    s1_rxd;
    logic [3:0]    candidate;
    logic [3:0]    cand_next;
    logic [3:0]    committed;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] match_next;
    logic          reached;
    logic [SW-1:0] stale_cnt;
    logic [SW-1:0] stale_next;
    logic          qual;
    logic          reserved;
    logic          do_commit;
    logic          load_speed;

    assign qual     = ~s1_ctl_rise & ~s1_ctl_fall;
    assign reserved = (s1_rxd[2:1] == 2'b11);

    // Non-qualified samples leave candidate and count untouched.
    always_comb begin
        match_next = match_cnt;
        cand_next  = candidate;
        if (qual) begin
            if (reserved) begin
                match_next = '0;
            end else if (s1_rxd == candidate) begin
                if (match_cnt != MATCH_MAX)
                    match_next = match_cnt + MW'(1);
            end else begin
                cand_next  = s1_rxd;
                match_next = MW'(1);
            end
        end
    end

    always_comb begin
        stale_next = stale_cnt;
        if (qual)
            stale_next = '0;
        else if (stale_cnt != STALE_MAX)
            stale_next = stale_cnt + SW'(1);
    end

    assign do_commit  = reached && ((candidate != committed) || !status_valid);
    // A link-down commit keeps the last speed so the outputs stay one-hot once valid.
    assign load_speed = candidate[0] || !status_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_ctl_rise    <= 1'b0;
            s1_ctl_fall    <= 1'b0;
            s1_rxd         <= '0;
            candidate      <= '0;
            match_cnt      <= '0;
            reached        <= 1'b0;
            committed      <= '0;
            stale_cnt      <= '0;
            status_stale   <= 1'b0;
            bad_code_count <= '0;
            rx_link_up     <= 1'b0;
            rx_full_duplex <= 1'b0;
            rx_speed_10    <= 1'b0;
            rx_speed_100   <= 1'b0;
            rx_speed_1000  <= 1'b0;
            status_valid   <= 1'b0;
            status_changed <= 1'b0;
        end else begin
            s1_ctl_rise  <= rx_ctl_rise;
            s1_ctl_fall  <= rx_ctl_fall;
            s1_rxd       <= rxd_rise;
            candidate    <= cand_next;
            match_cnt    <= match_next;
            reached      <= (match_next == MATCH_MAX) && (match_cnt != MATCH_MAX);
            stale_cnt    <= stale_next;
            status_stale <= (stale_next == STALE_MAX);
            if (qual && reserved && (bad_code_count != {BAD_COUNT_BITS{1'b1}}))
                bad_code_count <= bad_code_count + BAD_COUNT_BITS'(1);
            status_changed <= do_commit;
            if (do_commit) begin
                committed      <= candidate;
                rx_link_up     <= candidate[0];
                rx_full_duplex <= candidate[3];
                status_valid   <= 1'b1;
                if (load_speed) begin
                    rx_speed_10   <= (candidate[2:1] == 2'b00);
                    rx_speed_100  <= (candidate[2:1] == 2'b01);
                    rx_speed_1000 <= (candidate[2:1] == 2'b10);
                end
            end
        end
    end

endmodule

// File: tb/tb_rgmii_inband_status.sv
// Bench for rgmii_inband_status: commits are predicted into a queue and matched when status_changed pulses.
module tb_rgmii_inband_status;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_ctl_rise = 1'b0;
    logic       rx_ctl_fall = 1'b0;
    logic [3:0] rxd_rise = 4'h0;
    logic       rx_link_up, rx_speed_10, rx_speed_100, rx_speed_1000, rx_full_duplex;
    logic       status_valid, status_changed, status_stale;
    logic [7:0] bad_code_count;

    rgmii_inband_status dut (
        .clk            (clk),
        .reset          (reset),
        .rx_ctl_rise    (rx_ctl_rise),
        .rx_ctl_fall    (rx_ctl_fall),
        .rxd_rise       (rxd_rise),
        .rx_link_up     (rx_link_up),
        .rx_speed_10    (rx_speed_10),
        .rx_speed_100   (rx_speed_100),
        .rx_speed_1000  (rx_speed_1000),
        .rx_full_duplex (rx_full_duplex),
        .status_valid   (status_valid),
        .status_changed (status_changed),
        .status_stale   (status_stale),
        .bad_code_count (bad_code_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    logic [5:0] exp_vec[$];
    int         exp_edge[$];

    logic [5:0]  st_vec;
    logic [16:0] all_out;
    assign st_vec  = {rx_link_up, rx_speed_10, rx_speed_100, rx_speed_1000, rx_full_duplex, status_valid};
    assign all_out = {st_vec, status_changed, status_stale, bad_code_count};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic cr, input logic cf, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_ctl_rise = cr;
            rx_ctl_fall = cf;
            rxd_rise    = d;
        end
    endtask

    // Called right after the final matching sample is set up: captured on the next edge, visible two edges later.
    task automatic expect_commit(input logic [5:0] v);
        exp_vec.push_back(v);
        exp_edge.push_back(edge_cnt + 3);
    endtask

    always @(negedge clk) begin
        if (!reset && status_changed) begin
            if (exp_vec.size() == 0) begin
                chk_val("unexpected_commit", 32'(st_vec), 32'h0);
            end else begin
                chk_val("commit_state", 32'(st_vec), 32'(exp_vec.pop_front()));
                chk_val("commit_edge", 32'(edge_cnt), 32'(exp_edge.pop_front()));
            end
        end
    end

    initial begin
        #1;
        chk_val("reset_outputs", 32'(all_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 7 samples, frame data, then 8th: commit 1000/up/full
        drive(1'b0, 1'b0, 4'b1101, 7);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("no_commit_after_7", 32'(status_valid), 32'h0);
        drive(1'b0, 1'b0, 4'b1101, 1);
        expect_commit(6'b100111);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("state_1000", 32'(st_vec), 32'b100111);

        // interrupted at 7, then clean 8: commit 100
        drive(1'b0, 1'b0, 4'b1011, 7);
        drive(1'b0, 1'b0, 4'b1010, 1);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("interrupted_no_commit", 32'(st_vec), 32'b100111);
        drive(1'b0, 1'b0, 4'b1011, 8);
        expect_commit(6'b101011);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("state_100", 32'(st_vec), 32'b101011);

        // link down keeps speed
        drive(1'b0, 1'b0, 4'b0000, 8);
        expect_commit(6'b001001);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("state_link_down", 32'(st_vec), 32'b001001);
        chk_val("bad_count_zero", 32'(bad_code_count), 32'h0);

        // non-qualified gap does not break the run
        drive(1'b0, 1'b0, 4'b1101, 4);
        drive(1'b1, 1'b0, 4'b0000, 10);
        drive(1'b0, 1'b1, 4'b0000, 10);
        drive(1'b0, 1'b0, 4'b1101, 4);
        expect_commit(6'b100111);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("state_after_gap", 32'(st_vec), 32'b100111);

        // reserved codes saturate the counter, no state change
        drive(1'b0, 1'b0, 4'b0111, 300);
        drive(1'b1, 1'b0, 4'b0000, 1021);
        chk_val("bad_count_sat", 32'(bad_code_count), 32'd255);
        chk_val("state_after_reserved", 32'(st_vec), 32'b100111);
        chk_val("stale_not_yet", 32'(status_stale), 32'h0);
        drive(1'b1, 1'b0, 4'b0000, 8);
        chk_val("stale_set", 32'(status_stale), 32'h1);
        chk_val("state_while_stale", 32'(st_vec), 32'b100111);
        drive(1'b0, 1'b0, 4'b1101, 1);
        drive(1'b1, 1'b0, 4'b0000, 2);
        chk_val("stale_cleared", 32'(status_stale), 32'h0);
        chk_val("state_after_stale", 32'(st_vec), 32'b100111);

        // async reset with match count at 7
        drive(1'b0, 1'b0, 4'b0011, 7);
        drive(1'b1, 1'b0, 4'b0000, 2);
        #2 reset = 1'b1;
        #1;
        chk_val("async_reset", 32'(all_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'b0011, 7);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("post_reset_7", 32'(st_vec), 32'h0);
        drive(1'b0, 1'b0, 4'b0011, 1);
        expect_commit(6'b101001);
        drive(1'b1, 1'b0, 4'b0000, 4);
        chk_val("post_reset_commit", 32'(st_vec), 32'b101001);

        chk_val("missing_commits", 32'(exp_vec.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
